// File: rtl/rf_wb_sched_pkg.sv
// rtl/rf_wb_sched_pkg.sv - shared constants and types for the write-back scheduler
package rf_wb_sched_pkg;

  localparam int REG_X0  = 0;
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Write-back beat as produced by execute and the LSU
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_beat_t;

  // Requester favoured on the next contention
  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

endpackage

// File: rtl/rf_wb_sched_if.sv
// rtl/rf_wb_sched_if.sv - write-back, issue/check and register-file port bundle
interface rf_wb_sched_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;
  logic [ADDR_WIDTH-1:0] chk_rs1;
  logic [ADDR_WIDTH-1:0] chk_rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  flush;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH:0]   pending_cnt;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2, flush,
    output req0_ready, req1_ready, iss_ready, rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wdata, pending_cnt
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2, flush,
    input  req0_ready, req1_ready, iss_ready, rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wdata, pending_cnt
  );

endinterface

// File: rtl/rf_wb_sched_rr_arb2.sv
// rtl/rf_wb_sched_rr_arb2.sv - two-way round-robin arbiter, pointer advances on grant
module rr_arb2
  import rf_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  prio_e prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (!rst) prio_q <= PRIO_ALU;
    else      prio_q <= prio_d;
  end

  // A grant is always an accepted transfer, so the pointer moves past every winner
  always_comb begin
    grant_o = 2'b00;
    prio_d  = prio_q;
    if (valid_i == 2'b11) grant_o[prio_q] = 1'b1;
    else                  grant_o = valid_i;
    if (grant_o[REQ_ALU])      prio_d = PRIO_LSU;
    else if (grant_o[REQ_LSU]) prio_d = PRIO_ALU;
  end

endmodule

// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file write-back scheduler with pending-write scoreboard
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_sched_if.slave  wb
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);

  logic [1:0]            grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  iss_ok;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       pend_q, pend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({wb.req1_valid, wb.req0_valid}),
    .grant_o (grant)
  );

  assign accept   = |grant;
  assign sel_addr = grant[REQ_LSU] ? wb.req1_addr : wb.req0_addr;
  assign sel_data = grant[REQ_LSU] ? wb.req1_data : wb.req0_data;
  assign iss_ok   = !pend_q[wb.iss_rd] || (wb.iss_rd == X0);

  always_comb begin
    we_d    = accept && (sel_addr != X0);
    waddr_d = accept ? sel_addr : waddr_q;
    wdata_d = accept ? sel_data : wdata_q;
  end

  // Clear retires on the register-file write edge; flush wins over any issue set
  always_comb begin
    pend_d = pend_q;
    if (we_q && (waddr_q != X0)) pend_d[waddr_q] = 1'b0;
    if (wb.iss_valid && iss_ok && (wb.iss_rd != X0)) pend_d[wb.iss_rd] = 1'b1;
    if (wb.flush) pend_d = '0;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.req0_ready  = grant[REQ_ALU];
  assign wb.req1_ready  = grant[REQ_LSU];
  assign wb.iss_ready   = iss_ok;
  assign wb.rs1_busy    = (wb.chk_rs1 != X0) && pend_q[wb.chk_rs1];
  assign wb.rs2_busy    = (wb.chk_rs2 != X0) && pend_q[wb.chk_rs2];
  assign wb.rf_we       = we_q;
  assign wb.rf_waddr    = waddr_q;
  assign wb.rf_wdata    = wdata_q;
  assign wb.pending_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb/tb_rf_wb_sched.sv - directed self-checking bench for rf_wb_sched
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rf_wb_sched_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb ();

  rf_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb.req0_valid = 1'b0; wb.req0_addr = '0; wb.req0_data = '0;
    wb.req1_valid = 1'b0; wb.req1_addr = '0; wb.req1_data = '0;
    wb.iss_valid  = 1'b0; wb.iss_rd    = '0;
    wb.chk_rs1    = '0;   wb.chk_rs2   = '0;
    wb.flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    wb.iss_rd = 5'd9;
    #1;
    n_checks++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", wb.rf_we); end
    n_checks++; if (wb.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", wb.rf_waddr); end
    n_checks++; if (wb.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wb.rf_wdata); end
    n_checks++; if (wb.pending_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", wb.pending_cnt); end
    n_checks++; if ({wb.req0_ready, wb.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {wb.req0_ready, wb.req1_ready}); end
    n_checks++; if (wb.iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready: got %0b want 1", wb.iss_ready); end
    idle();
  endtask

  task automatic test_single();
    do_reset();
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd5; wb.req0_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (wb.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", wb.req0_ready); end
    n_checks++; if (wb.req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_other_ready: got %0b want 0", wb.req1_ready); end
    step();
    idle();
    n_checks++; if (wb.rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %0b want 1", wb.rf_we); end
    n_checks++; if (wb.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL single_waddr: got %0d want 5", wb.rf_waddr); end
    n_checks++; if (wb.rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", wb.rf_wdata); end
    step();
    n_checks++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %0b want 0", wb.rf_we); end
  endtask

  task automatic test_back_to_back();
    logic       exp_r0 [4];
    logic [4:0] exp_addr [4];
    int a0, a1;
    exp_r0   = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_addr = '{5'd1, 5'd11, 5'd2, 5'd12};
    a0 = 0; a1 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wb.req0_valid = 1'b1; wb.req0_addr = 5'(1 + a0);  wb.req0_data = 32'h1000_0000 + 32'(1 + a0);
      wb.req1_valid = 1'b1; wb.req1_addr = 5'(11 + a1); wb.req1_data = 32'h2000_0000 + 32'(11 + a1);
      #1;
      n_checks++;
      if ({wb.req0_ready, wb.req1_ready} !== {exp_r0[k], ~exp_r0[k]}) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {wb.req0_ready, wb.req1_ready}, {exp_r0[k], ~exp_r0[k]});
      end
      step();
      n_checks++;
      if (wb.rf_we !== 1'b1 || wb.rf_waddr !== exp_addr[k]) begin
        n_fail++; $display("FAIL rr_waddr[%0d]: got we=%0b addr=%0d want we=1 addr=%0d", k, wb.rf_we, wb.rf_waddr, exp_addr[k]);
      end
      if (exp_r0[k]) a0++; else a1++;
    end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd7; wb.chk_rs1 = 5'd7;
    #1;
    n_checks++; if (wb.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy_before: got %0b want 0", wb.rs1_busy); end
    step();
    wb.iss_valid = 1'b0;
    n_checks++; if (wb.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy_set: got %0b want 1", wb.rs1_busy); end
    n_checks++; if (wb.pending_cnt !== 6'd1) begin n_fail++; $display("FAIL raw_cnt_set: got %0d want 1", wb.pending_cnt); end
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd7; wb.req1_data = 32'h0000_0777;
    #1;
    n_checks++; if (wb.req1_ready !== 1'b1) begin n_fail++; $display("FAIL raw_req1_ready: got %0b want 1", wb.req1_ready); end
    step();
    wb.req1_valid = 1'b0;
    n_checks++; if (wb.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy_n1: got %0b want 1", wb.rs1_busy); end
    step();
    n_checks++; if (wb.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy_n2: got %0b want 0", wb.rs1_busy); end
    n_checks++; if (wb.pending_cnt !== 6'd0) begin n_fail++; $display("FAIL raw_cnt_clr: got %0d want 0", wb.pending_cnt); end
    idle();
  endtask

  task automatic test_waw_x0();
    do_reset();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd9;
    step();
    #1;
    n_checks++; if (wb.iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_iss_ready: got %0b want 0", wb.iss_ready); end
    step();
    n_checks++; if (wb.pending_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_cnt: got %0d want 1", wb.pending_cnt); end
    wb.iss_rd = 5'd0; wb.chk_rs2 = 5'd0;
    #1;
    n_checks++; if (wb.iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_iss_ready: got %0b want 1", wb.iss_ready); end
    n_checks++; if (wb.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_rs2_busy: got %0b want 0", wb.rs2_busy); end
    step();
    wb.iss_valid = 1'b0;
    n_checks++; if (wb.pending_cnt !== 6'd1) begin n_fail++; $display("FAIL x0_cnt: got %0d want 1", wb.pending_cnt); end
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd0; wb.req0_data = 32'h0000_0055;
    #1;
    n_checks++; if (wb.req0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", wb.req0_ready); end
    step();
    wb.req0_valid = 1'b0;
    n_checks++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0b want 0", wb.rf_we); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    wb.iss_valid = 1'b1;
    for (int r = 3; r <= 5; r++) begin
      wb.iss_rd = 5'(r);
      step();
    end
    n_checks++; if (wb.pending_cnt !== 6'd3) begin n_fail++; $display("FAIL flush_cnt_pre: got %0d want 3", wb.pending_cnt); end
    wb.iss_rd = 5'd6; wb.flush = 1'b1;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd3; wb.req0_data = 32'hA5A5_0003;
    #1;
    n_checks++; if (wb.req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_req0_ready: got %0b want 1", wb.req0_ready); end
    step();
    idle();
    wb.chk_rs1 = 5'd6; wb.chk_rs2 = 5'd4;
    #1;
    n_checks++; if (wb.pending_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", wb.pending_cnt); end
    n_checks++; if (wb.rs1_busy !== 1'b0 || wb.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0b%0b want 00", wb.rs1_busy, wb.rs2_busy); end
    n_checks++;
    if (wb.rf_we !== 1'b1 || wb.rf_waddr !== 5'd3 || wb.rf_wdata !== 32'hA5A5_0003) begin
      n_fail++; $display("FAIL flush_inflight: got we=%0b addr=%0d data=%h want we=1 addr=3 data=a5a50003", wb.rf_we, wb.rf_waddr, wb.rf_wdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd8; wb.req0_data = 32'h0000_0888;
    wb.iss_valid  = 1'b1; wb.iss_rd    = 5'd8;
    step();
    idle();
    n_checks++; if (wb.rf_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_before: got %0b want 1", wb.rf_we); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_we_dropped: got %0b want 0", wb.rf_we); end
    n_checks++; if (wb.pending_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", wb.pending_cnt); end
    n_checks++; if (wb.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL mid_waddr: got %0d want 0", wb.rf_waddr); end
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd2;  wb.req0_data = 32'h2;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd12; wb.req1_data = 32'hC;
    #1;
    n_checks++; if ({wb.req0_ready, wb.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_prio: got %b want 10", {wb.req0_ready, wb.req1_ready}); end
    step();
    idle();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();
    test_reset();
    test_single();
    test_back_to_back();
    test_raw();
    test_waw_x0();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
